// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the M-stage memory access sequencer:
// load/store opcodes, access sizes, FSM states and small opcode decode helpers.
package mem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } mem_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  function automatic logic is_store(input mem_op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_signed_load(input mem_op_e op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

  function automatic size_e op_size(input mem_op_e op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      default:              return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data bus: alignment check, byte enables,
// store-data replication and load extraction with sign/zero extension.
// Purely combinational; no state, no backpressure.
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  mem_op_e     op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic        aligned_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sgn;

  // Decode size, pick the addressed lane(s) and build all outputs.
  always_comb begin
    aligned_o = 1'b1;
    be_o      = 4'b1111;
    wdata_o   = wdata_i;
    ld_o      = rdata_i;
    sgn       = is_signed_load(op_i);
    half_sel  = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    case (op_size(op_i))
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        ld_o    = {{24{sgn & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        aligned_o = ~addr_lo_i[0];
        be_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o   = {2{wdata_i[15:0]}};
        ld_o      = {{16{sgn & half_sel[15]}}, half_sel};
      end
      default: begin
        aligned_o = (addr_lo_i == 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// M-stage load/store sequencer driving a req/ack data bus with lane steering.
// Latency: 3+ cycles per access (accept, WAIT until ack or timeout, DONE).
// Backpressure: stall held from accept through WAIT; bus_req held until bus_ack.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        exc_bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mem_op_e           op_q, op_d;
  logic [1:0]        lo_q, lo_d;
  logic              req_q, req_d, we_q, we_d;
  logic [31:0]       baddr_q, baddr_d, bwdata_q, bwdata_d, ld_q, ld_d;
  logic [3:0]        be_q, be_d;
  logic              ldv_q, ldv_d, adel_q, adel_d, ades_q, ades_d, ebus_q, ebus_d;

  mem_op_e           cur_op, sel_op;
  logic [1:0]        sel_lo;
  logic              lane_aligned;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata, lane_ld;

  // While waiting the lane logic extracts load data for the captured access;
  // otherwise it evaluates the incoming instruction.
  always_comb begin
    cur_op = mem_op_e'(mem_op);
    sel_op = (state_q == S_WAIT) ? op_q : cur_op;
    sel_lo = (state_q == S_WAIT) ? lo_q : addr[1:0];
  end

  mem_lane_align u_lane (
    .op_i      (sel_op),
    .addr_lo_i (sel_lo),
    .wdata_i   (wdata),
    .rdata_i   (bus_rdata),
    .aligned_o (lane_aligned),
    .be_o      (lane_be),
    .wdata_o   (lane_wdata),
    .ld_o      (lane_ld)
  );

  // Next-state, timeout counter, bus/result register updates and stall.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    lo_d     = lo_q;
    req_d    = req_q;
    we_d     = we_q;
    baddr_d  = baddr_q;
    be_d     = be_q;
    bwdata_d = bwdata_q;
    ld_d     = ld_q;
    ldv_d    = 1'b0;
    adel_d   = 1'b0;
    ades_d   = 1'b0;
    ebus_d   = 1'b0;
    stall    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          if (lane_aligned) begin
            stall    = 1'b1;
            state_d  = S_WAIT;
            cnt_d    = '0;
            op_d     = cur_op;
            lo_d     = addr[1:0];
            req_d    = 1'b1;
            we_d     = is_store(cur_op);
            baddr_d  = {addr[31:2], 2'b00};
            be_d     = lane_be;
            bwdata_d = lane_wdata;
          end else begin
            adel_d = ~is_store(cur_op);
            ades_d = is_store(cur_op);
          end
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (bus_ack) begin
          req_d   = 1'b0;
          state_d = S_DONE;
          if (!is_store(op_q)) begin
            ld_d  = lane_ld;
            ldv_d = 1'b1;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          ebus_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_LB;
      lo_q     <= 2'b00;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      baddr_q  <= '0;
      be_q     <= '0;
      bwdata_q <= '0;
      ld_q     <= '0;
      ldv_q    <= 1'b0;
      adel_q   <= 1'b0;
      ades_q   <= 1'b0;
      ebus_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      lo_q     <= lo_d;
      req_q    <= req_d;
      we_q     <= we_d;
      baddr_q  <= baddr_d;
      be_q     <= be_d;
      bwdata_q <= bwdata_d;
      ld_q     <= ld_d;
      ldv_q    <= ldv_d;
      adel_q   <= adel_d;
      ades_q   <= ades_d;
      ebus_q   <= ebus_d;
    end
  end

  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = baddr_q;
  assign bus_be    = be_q;
  assign bus_wdata = bwdata_q;
  assign ld_data   = ld_q;
  assign ld_valid  = ldv_q;
  assign exc_adel  = adel_q;
  assign exc_ades  = ades_q;
  assign exc_bus   = ebus_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a vector table of complete accesses
// plus hand sequences for reset, bus timeout and reset during WAIT.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic [2:0]  mem_op;
  logic [31:0] addr, wdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ack, stall;
  logic [31:0] ld_data;
  logic        ld_valid, exc_adel, exc_ades, exc_bus;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_op    (mem_op),
    .addr      (addr),
    .wdata     (wdata),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .stall     (stall),
    .ld_data   (ld_data),
    .ld_valid  (ld_valid),
    .exc_adel  (exc_adel),
    .exc_ades  (exc_ades),
    .exc_bus   (exc_bus)
  );

  typedef struct {
    mem_op_e     op;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          ack_at;
    logic        adel;
    logic        ades;
    logic        we;
    logic [3:0]  be;
    logic [31:0] baddr;
    logic [31:0] bwd;
    logic [31:0] ld;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input mem_op_e op, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int ack_at, input logic adel,
                              input logic ades, input logic we, input logic [3:0] be,
                              input logic [31:0] baddr, input logic [31:0] bwd,
                              input logic [31:0] ld);
    vec_t v;
    v.op = op; v.a = a; v.wd = wd; v.rd = rd; v.ack_at = ack_at;
    v.adel = adel; v.ades = ades; v.we = we; v.be = be;
    v.baddr = baddr; v.bwd = bwd; v.ld = ld;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int stall_sum;
    logic ok;
    ok = !(v.adel || v.ades);
    @(negedge clk);
    mem_valid = 1'b1; mem_op = v.op; addr = v.a; wdata = v.wd; bus_ack = 1'b0;
    #1;
    chk("stall_accept", {31'd0, stall}, {31'd0, ok});
    chk("req_idle", {31'd0, bus_req}, 32'd0);
    if (ok) begin
      stall_sum = int'(stall);
      for (int c = 1; c <= v.ack_at; c++) begin
        @(negedge clk);
        bus_rdata = v.rd;
        bus_ack   = (c == v.ack_at);
        #1;
        stall_sum += int'(stall);
        chk("req_wait", {31'd0, bus_req}, 32'd1);
        chk("bus_addr", bus_addr, v.baddr);
        chk("bus_be", {28'd0, bus_be}, {28'd0, v.be});
        chk("bus_we", {31'd0, bus_we}, {31'd0, v.we});
        if (v.we) chk("bus_wdata", bus_wdata, v.bwd);
      end
      @(negedge clk);
      bus_ack = 1'b0; mem_valid = 1'b0;
      #1;
      chk("stall_cycles", stall_sum, 1 + v.ack_at);
      chk("stall_done", {31'd0, stall}, 32'd0);
      chk("req_done", {31'd0, bus_req}, 32'd0);
      chk("ld_valid_done", {31'd0, ld_valid}, {31'd0, ~v.we});
      if (!v.we) chk("ld_data", ld_data, v.ld);
      @(negedge clk);
      #1;
      chk("ld_valid_idle", {31'd0, ld_valid}, 32'd0);
    end else begin
      @(negedge clk);
      mem_valid = 1'b0;
      #1;
      chk("exc_adel", {31'd0, exc_adel}, {31'd0, v.adel});
      chk("exc_ades", {31'd0, exc_ades}, {31'd0, v.ades});
      chk("req_misaligned", {31'd0, bus_req}, 32'd0);
      @(negedge clk);
      #1;
      chk("exc_pulse_end", {30'd0, exc_adel, exc_ades}, 32'd0);
      chk("req_misaligned2", {31'd0, bus_req}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cnt;
    logic seen;
    logic [31:0] last_ld;

    //          op      addr         wdata        rdata        ack adel ades we be       baddr        bwdata       ld
    vecs.push_back(mk(OP_LW,  32'h10,  32'h0,        32'hDEADBEEF, 2, 0, 0, 0, 4'b1111, 32'h10,  32'h0,        32'hDEADBEEF));
    vecs.push_back(mk(OP_LB,  32'h13,  32'h0,        32'h80112233, 1, 0, 0, 0, 4'b1000, 32'h10,  32'h0,        32'hFFFFFF80));
    vecs.push_back(mk(OP_LBU, 32'h13,  32'h0,        32'h80112233, 1, 0, 0, 0, 4'b1000, 32'h10,  32'h0,        32'h00000080));
    vecs.push_back(mk(OP_SH,  32'h22,  32'h1234ABCD, 32'h0,        1, 0, 0, 1, 4'b1100, 32'h20,  32'hABCDABCD, 32'h0));
    vecs.push_back(mk(OP_LW,  32'h02,  32'h0,        32'h0,        1, 1, 0, 0, 4'b0000, 32'h0,   32'h0,        32'h0));
    vecs.push_back(mk(OP_SH,  32'h01,  32'h0,        32'h0,        1, 0, 1, 1, 4'b0000, 32'h0,   32'h0,        32'h0));
    vecs.push_back(mk(OP_LH,  32'h06,  32'h0,        32'h80017FFF, 3, 0, 0, 0, 4'b1100, 32'h04,  32'h0,        32'hFFFF8001));
    vecs.push_back(mk(OP_LHU, 32'h04,  32'h0,        32'h8001F00D, 1, 0, 0, 0, 4'b0011, 32'h04,  32'h0,        32'h0000F00D));
    vecs.push_back(mk(OP_SB,  32'h41,  32'h000000A5, 32'h0,        1, 0, 0, 1, 4'b0010, 32'h40,  32'hA5A5A5A5, 32'h0));
    vecs.push_back(mk(OP_SW,  32'h03,  32'h0,        32'h0,        1, 0, 1, 1, 4'b0000, 32'h0,   32'h0,        32'h0));
    vecs.push_back(mk(OP_LH,  32'h03,  32'h0,        32'h0,        1, 1, 0, 0, 4'b0000, 32'h0,   32'h0,        32'h0));
    vecs.push_back(mk(OP_LB,  32'h01,  32'h0,        32'h00007F00, 1, 0, 0, 0, 4'b0010, 32'h00,  32'h0,        32'h0000007F));
    vecs.push_back(mk(OP_SW,  32'h100, 32'hCAFEF00D, 32'h0,        2, 0, 0, 1, 4'b1111, 32'h100, 32'hCAFEF00D, 32'h0));

    reset = 1'b1; mem_valid = 1'b0; mem_op = 3'd0; addr = '0; wdata = '0;
    bus_rdata = '0; bus_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_we", {31'd0, bus_we}, 32'd0);
    chk("rst_be", {28'd0, bus_be}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    chk("rst_flags", {28'd0, ld_valid, exc_adel, exc_ades, exc_bus}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    last_ld = 32'd0;
    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i]);
      if (!vecs[i].we && !vecs[i].adel && !vecs[i].ades) last_ld = vecs[i].ld;
    end
    #1;
    chk("ld_hold", ld_data, last_ld);

    // Bus never acknowledges: expect exactly 64 request cycles then exc_bus.
    @(negedge clk);
    mem_valid = 1'b1; mem_op = OP_LW; addr = 32'h80; bus_ack = 1'b0;
    #1;
    chk("to_stall_accept", {31'd0, stall}, 32'd1);
    wait_cnt = 0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (exc_bus) begin
        seen = 1'b1;
        mem_valid = 1'b0;
      end else if (bus_req) begin
        wait_cnt++;
      end
    end
    chk("to_seen", {31'd0, seen}, 32'd1);
    chk("to_wait_cycles", wait_cnt, 64);
    chk("to_req_low", {31'd0, bus_req}, 32'd0);
    chk("to_stall_low", {31'd0, stall}, 32'd0);
    chk("to_no_ld_valid", {31'd0, ld_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("to_pulse_end", {31'd0, exc_bus}, 32'd0);
    chk("to_ld_hold", ld_data, last_ld);

    // Reset in the middle of WAIT aborts the access.
    @(negedge clk);
    mem_valid = 1'b1; mem_op = OP_LW; addr = 32'h20;
    @(negedge clk);
    #1;
    chk("rw_req_wait", {31'd0, bus_req}, 32'd1);
    @(negedge clk);
    reset = 1'b1; mem_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rw_req", {31'd0, bus_req}, 32'd0);
    chk("rw_stall", {31'd0, stall}, 32'd0);
    chk("rw_ld_valid", {31'd0, ld_valid}, 32'd0);
    chk("rw_ld_data", ld_data, 32'd0);
    bus_rdata = 32'h55555555; bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    chk("stray_ack_ld_valid", {31'd0, ld_valid}, 32'd0);
    chk("stray_ack_ld_data", ld_data, 32'd0);
    chk("stray_ack_req", {31'd0, bus_req}, 32'd0);

    // Controller is back in IDLE and accepts a fresh access.
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
